// File: rtl/scan_pkg.sv
// Shared types and digit-search helpers for the multiplexed digit scanner.
package scan_pkg;

    localparam int unsigned NUM_DIGITS = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_ON    = 2'd2
    } scan_state_e;

    typedef struct packed {
        logic [1:0] idx;
        logic       wrap;
    } next_digit_t;

    // Next enabled digit above cur, wrapping 3->0; wrap is set when the search
    // lands at or below cur, i.e. the frame is complete.
    function automatic next_digit_t next_digit(input logic [1:0]            cur,
                                               input logic [NUM_DIGITS-1:0] mask);
        next_digit_t r;
        logic        found;
        logic [1:0]  cand;
        r.idx  = cur;
        r.wrap = 1'b0;
        found  = 1'b0;
        for (int unsigned i = 1; i <= NUM_DIGITS; i++) begin
            cand = cur + 2'(i);
            if (!found && mask[cand]) begin
                found  = 1'b1;
                r.idx  = cand;
                r.wrap = (cand <= cur);
            end
        end
        return r;
    endfunction

    function automatic logic [1:0] first_digit(input logic [NUM_DIGITS-1:0] mask);
        logic [1:0] r;
        logic       found;
        r     = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (!found && mask[2'(i)]) begin
                found = 1'b1;
                r     = 2'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/digit_scan_ctrl_phase_counter.sv
// Loadable down-counter that times both the blanking gap and the digit dwell.
module phase_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/digit_scan_ctrl.sv
// Steps sel/en for a clocked 2-to-4 digit decoder: blank gap, then dwell, per enabled digit.
module digit_scan_ctrl
    import scan_pkg::*;
#(
    parameter int unsigned DWELL = 8,
    parameter int unsigned BLANK = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  run,
    input  logic [NUM_DIGITS-1:0] digit_mask,
    output logic [1:0]            sel,
    output logic                  en,
    output logic                  frame_done,
    output logic                  busy
);

    localparam int unsigned CNT_MAX = (32'd1 << CNT_W) - 32'd1;

    if (DWELL < 1 || DWELL > CNT_MAX || BLANK > CNT_MAX) begin : g_param_check
        $error("digit_scan_ctrl: DWELL must be 1..2^CNT_W-1 and BLANK at most 2^CNT_W-1");
    end

    localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] BLANK_LD = CNT_W'((BLANK == 0) ? 0 : BLANK - 1);
    localparam bit               NO_BLANK = (BLANK == 0);

    scan_state_e      state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic             en_q, en_d;
    logic             frame_done_q, frame_done_d;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_zero;
    next_digit_t      nd;

    phase_counter #(
        .CNT_W(CNT_W)
    ) u_phase_counter (
        .clk_i      (clock),
        .rst_ni     (reset_n),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .zero_o     (cnt_zero)
    );

    assign nd = next_digit(sel_q, digit_mask);

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        frame_done_d = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = DWELL_LD;
        unique case (state_q)
            ST_IDLE: begin
                if (run && (digit_mask != '0)) begin
                    sel_d    = first_digit(digit_mask);
                    cnt_load = 1'b1;
                    if (NO_BLANK) begin
                        state_d = ST_ON;
                    end else begin
                        state_d      = ST_BLANK;
                        cnt_load_val = BLANK_LD;
                    end
                end
            end
            ST_BLANK: begin
                if (!run) begin
                    state_d = ST_IDLE;
                end else if (cnt_zero) begin
                    state_d  = ST_ON;
                    cnt_load = 1'b1;
                end
            end
            ST_ON: begin
                // Dwell always runs to completion; run and mask only matter at its last cycle.
                if (cnt_zero) begin
                    if (digit_mask == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        frame_done_d = nd.wrap;
                        if (!run) begin
                            state_d = ST_IDLE;
                        end else begin
                            sel_d    = nd.idx;
                            cnt_load = 1'b1;
                            if (NO_BLANK) begin
                                state_d = ST_ON;
                            end else begin
                                state_d      = ST_BLANK;
                                cnt_load_val = BLANK_LD;
                            end
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        en_d = (state_d == ST_ON);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            sel_q        <= '0;
            en_q         <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            en_q         <= en_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign sel        = sel_q;
    assign en         = en_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Bench for digit_scan_ctrl: positional timeline model plus directed literal checks.
module tb_digit_scan_ctrl;

    localparam int A_DWELL = 4;
    localparam int A_BLANK = 2;
    localparam int B_DWELL = 1;
    localparam int B_BLANK = 0;

    logic       clock;
    logic       reset_n;
    logic       run_a, run_b;
    logic [3:0] mask_a, mask_b;
    logic [1:0] sel_a, sel_b;
    logic       en_a, en_b, fd_a, fd_b, busy_a, busy_b;

    int tests = 0;
    int fails = 0;

    digit_scan_ctrl #(
        .DWELL(A_DWELL),
        .BLANK(A_BLANK),
        .CNT_W(8)
    ) dut_a (
        .clock      (clock),
        .reset_n    (reset_n),
        .run        (run_a),
        .digit_mask (mask_a),
        .sel        (sel_a),
        .en         (en_a),
        .frame_done (fd_a),
        .busy       (busy_a)
    );

    digit_scan_ctrl #(
        .DWELL(B_DWELL),
        .BLANK(B_BLANK),
        .CNT_W(4)
    ) dut_b (
        .clock      (clock),
        .reset_n    (reset_n),
        .run        (run_b),
        .digit_mask (mask_b),
        .sel        (sel_b),
        .en         (en_b),
        .frame_done (fd_b),
        .busy       (busy_b)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Model: a digit occupies a period of b+d cycles; pos is the offset within it.
    typedef struct packed {
        bit active;
        int pos;
        int cur;
        bit fd;
    } mstate_t;

    mstate_t ma, mb;

    function automatic int first_after(input int cur, input logic [3:0] m);
        int dd;
        for (int k = 1; k <= 4; k++) begin
            dd = (cur + k) % 4;
            if (m[dd[1:0]]) return dd;
        end
        return cur;
    endfunction

    function automatic mstate_t mstep(input mstate_t s, input logic r, input logic [3:0] m,
                                      input int b, input int d);
        mstate_t n;
        int      nxt;
        n    = s;
        n.fd = 1'b0;
        if (!s.active) begin
            if (r && m != 4'b0) begin
                n.active = 1'b1;
                n.pos    = 0;
                n.cur    = first_after(3, m);
            end
        end else if (s.pos < b) begin
            if (!r) n.active = 1'b0;
            else    n.pos    = s.pos + 1;
        end else if (s.pos == b + d - 1) begin
            if (m == 4'b0) begin
                n.active = 1'b0;
            end else begin
                nxt  = first_after(s.cur, m);
                n.fd = (nxt <= s.cur);
                if (!r) begin
                    n.active = 1'b0;
                end else begin
                    n.cur = nxt;
                    n.pos = 0;
                end
            end
        end else begin
            n.pos = s.pos + 1;
        end
        return n;
    endfunction

    function automatic logic [4:0] exp_vec(input mstate_t s, input int b);
        return {s.active, s.active && (s.pos >= b), s.cur[1:0], s.fd};
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ma <= '0;
            mb <= '0;
        end else begin
            ma <= mstep(ma, run_a, mask_a, A_BLANK, A_DWELL);
            mb <= mstep(mb, run_b, mask_b, B_BLANK, B_DWELL);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of {busy,en,sel,frame_done} against the model.
    initial begin
        forever begin
            @(negedge clock);
            check("model_a", 32'({busy_a, en_a, sel_a, fd_a}), 32'(exp_vec(ma, A_BLANK)));
            check("model_b", 32'({busy_b, en_b, sel_b, fd_b}), 32'(exp_vec(mb, B_BLANK)));
        end
    end

    task automatic wait_idle_a(input int maxc);
        int n;
        n = 0;
        while (busy_a !== 1'b0 && n < maxc) begin
            @(negedge clock);
            n++;
        end
        check("idle_timeout_a", 32'(busy_a), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b1;
        run_a   = 1'b0;
        run_b   = 1'b0;
        mask_a  = 4'b0;
        mask_b  = 4'b0;
        #1 reset_n = 1'b0;
        @(negedge clock);
        check("rst_sel", 32'(sel_a), 32'd0);
        check("rst_en", 32'(en_a), 32'd0);
        check("rst_fd", 32'(fd_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("idle_busy", 32'(busy_a), 32'd0);

        // All four digits: 2 blank + 4 on each, frame every 24 cycles.
        run_a  = 1'b1;
        mask_a = 4'hF;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            check("t1_busy", 32'(busy_a), 32'd1);
            check("t1_en", 32'(en_a), 32'((i % 6) >= 2));
            check("t1_sel", 32'(sel_a), 32'((i / 6) % 4));
            check("t1_fd", 32'(fd_a), 32'(i > 0 && (i % 24) == 0));
        end
        run_a = 1'b0;
        wait_idle_a(20);

        // Digits 1 and 3 only.
        mask_a = 4'b1010;
        run_a  = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            check("t2_en", 32'(en_a), 32'((i % 6) >= 2));
            check("t2_sel", 32'(sel_a), ((i / 6) % 2 == 1) ? 32'd3 : 32'd1);
            check("t2_fd", 32'(fd_a), 32'(i > 0 && (i % 12) == 0));
        end
        run_a = 1'b0;
        wait_idle_a(20);

        // run dropped during the second ON cycle: dwell completes.
        mask_a = 4'hF;
        run_a  = 1'b1;
        repeat (4) @(negedge clock);
        check("t3_on2_en", 32'(en_a), 32'd1);
        run_a = 1'b0;
        @(negedge clock);
        check("t3_on3_en", 32'(en_a), 32'd1);
        @(negedge clock);
        check("t3_on4_en", 32'(en_a), 32'd1);
        @(negedge clock);
        check("t3_end_busy", 32'(busy_a), 32'd0);
        check("t3_end_en", 32'(en_a), 32'd0);
        check("t3_end_fd", 32'(fd_a), 32'd0);
        check("t3_end_sel", 32'(sel_a), 32'd0);

        // run dropped during blanking: back to idle, en never rises.
        run_a = 1'b1;
        @(negedge clock);
        check("t3b_busy", 32'(busy_a), 32'd1);
        check("t3b_en", 32'(en_a), 32'd0);
        run_a = 1'b0;
        @(negedge clock);
        check("t3b_idle", 32'(busy_a), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("t3b_en_low", 32'(en_a), 32'd0);
        end

        // Mask cleared mid-dwell of digit 2, then restored as single digit 2.
        mask_a = 4'hF;
        run_a  = 1'b1;
        repeat (16) @(negedge clock);
        check("t4_sel2", 32'(sel_a), 32'd2);
        check("t4_on", 32'(en_a), 32'd1);
        mask_a = 4'b0;
        @(negedge clock);
        check("t4_on16", 32'(en_a), 32'd1);
        @(negedge clock);
        check("t4_on17", 32'(en_a), 32'd1);
        @(negedge clock);
        check("t4_idle_busy", 32'(busy_a), 32'd0);
        check("t4_idle_en", 32'(en_a), 32'd0);
        check("t4_idle_sel", 32'(sel_a), 32'd2);
        check("t4_idle_fd", 32'(fd_a), 32'd0);
        mask_a = 4'b0100;
        @(negedge clock);
        check("t4_restart_busy", 32'(busy_a), 32'd1);
        check("t4_restart_sel", 32'(sel_a), 32'd2);
        check("t4_restart_en", 32'(en_a), 32'd0);
        @(negedge clock);
        check("t4_blank2", 32'(en_a), 32'd0);
        @(negedge clock);
        check("t4_on_rise", 32'(en_a), 32'd1);
        repeat (3) @(negedge clock);
        check("t4_on_last", 32'(en_a), 32'd1);
        @(negedge clock);
        check("t4_single_fd", 32'(fd_a), 32'd1);
        check("t4_single_sel", 32'(sel_a), 32'd2);
        check("t4_single_en", 32'(en_a), 32'd0);
        run_a = 1'b0;
        wait_idle_a(20);

        // No blanking, one-cycle dwell, single digit 0.
        mask_b = 4'b0001;
        run_b  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            check("t5_en", 32'(en_b), 32'd1);
            check("t5_sel", 32'(sel_b), 32'd0);
            check("t5_busy", 32'(busy_b), 32'd1);
            check("t5_fd", 32'(fd_b), 32'(i > 0));
        end

        // Asynchronous reset during digit 1's dwell.
        mask_a = 4'hF;
        run_a  = 1'b1;
        repeat (10) @(negedge clock);
        check("t6_pre_sel", 32'(sel_a), 32'd1);
        check("t6_pre_en", 32'(en_a), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("t6_async_en", 32'(en_a), 32'd0);
        check("t6_async_sel", 32'(sel_a), 32'd0);
        check("t6_async_busy", 32'(busy_a), 32'd0);
        check("t6_async_fd", 32'(fd_a), 32'd0);
        check("t6_async_en_b", 32'(en_b), 32'd0);
        check("t6_async_busy_b", 32'(busy_b), 32'd0);
        run_a = 1'b0;
        run_b = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("t6_post_idle", 32'(busy_a), 32'd0);
        end
        run_a = 1'b1;
        @(negedge clock);
        check("t6_restart_busy", 32'(busy_a), 32'd1);
        check("t6_restart_sel", 32'(sel_a), 32'd0);
        check("t6_restart_en", 32'(en_a), 32'd0);
        run_a = 1'b0;
        wait_idle_a(20);
        repeat (2) @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/digit_scan_ctrl.md
# digit_scan_ctrl

Scan controller that drives the select and enable inputs of the clocked 2-to-4 decoder (`decoder2_4`). It steps `sel` through the enabled digits of a 4-digit multiplexed output, holding each digit on for a programmable dwell time. Between digits it inserts a blanking gap with `en` low to prevent ghosting. It sits directly upstream of the decoder and is the only source of its `sel`/`en`.

## Interface
- `DWELL`, 8: cycles `en` is held high per digit; legal range 1 to 2^CNT_W−1.
- `BLANK`, 2: cycles `en` is held low before each digit; legal range 0 to 2^CNT_W−1.
- `CNT_W`, 8: width of the internal phase counter.

- `clock`  in  1  single system clock, rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `run`  in  1  level; 1 = scanning requested.
- `digit_mask`  in  4  bit i = 1 means digit i takes part in the scan.
- `sel`  out  2  digit index to decoder; registered.
- `en`  out  1  decoder enable; registered; high only in ON state.
- `frame_done`  out  1  one-cycle pulse when the last enabled digit of a pass finishes its dwell.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- Reset values: `sel`=0, `en`=0, `frame_done`=0, `busy`=0; state IDLE; counter 0.
- States and transitions:
  - IDLE → BLANK when `run`=1 and `digit_mask`≠0.
    - `sel` loads the lowest set bit of the mask.
    - If BLANK=0, IDLE goes directly to ON.
  - BLANK: `en`=0 for BLANK cycles, then → ON.
  - ON: `en`=1 for DWELL cycles. At the last ON cycle, pick the next digit:
    - Search from `sel`+1 upward, wrapping 3→0, using `digit_mask` sampled that cycle.
    - If the search wraps, or `sel` is the highest set bit, pulse `frame_done`.
    - Then → BLANK (or ON if BLANK=0) with the new `sel`.
- `run` deassertion:
  - In ON, the current dwell completes. No truncated digit.
  - Then go to IDLE; `frame_done` still fires if this was the last digit.
  - In BLANK, go to IDLE on the next edge.
- Mask sampled as 0 at a digit-selection point → IDLE, `en`=0, `sel` unchanged.
- Single-digit mask: `sel` stays constant. BLANK/ON alternate, and `frame_done` pulses at every dwell end.
- Mask changes mid-dwell do not affect the current digit; they apply at the next selection only.
- Asynchronous reset mid-scan forces reset values immediately, with no `frame_done`.

## Timing
- `run` first sampled high at edge k: `busy`=1 after edge k; `en` rises after edge k+BLANK and stays high exactly DWELL cycles.
- `sel` changes only on the edge where `en` goes 0 (or during IDLE exit). It is never changed while `en`=1.
- Digit period is BLANK+DWELL cycles. Frame period is N·(BLANK+DWELL) for N enabled digits.
- `frame_done` is asserted in the cycle after the last ON cycle of the frame, coincident with `en` falling.
- The decoder adds its own one-register delay downstream; that delay is not compensated here.

## Structure
- Shared package `scan_pkg`:
  - state enum IDLE/BLANK/ON, 2-bit encoding;
  - `NUM_DIGITS`=4;
  - function `next_digit(cur, mask)`, which returns the index and a wrap flag.
- One natural sub-module: `phase_counter`, a loadable down-counter of CNT_W bits with a `zero` flag. It is reused for the BLANK and DWELL phases.
- Elaboration-time check rejects DWELL=0 or parameter values ≥ 2^CNT_W.

## Test plan
DWELL=4, BLANK=2 unless stated.
1. Reset, then `run`=1, mask=4'b1111 → `sel` runs 0,1,2,3,0. Each digit shows 2 cycles `en`=0 then 4 cycles `en`=1. `frame_done` pulses once every 24 cycles.
2. Mask=4'b1010 → `sel` alternates 1,3. `frame_done` fires after digit 3's dwell, every 12 cycles. Digits 0 and 2 never selected.
3. Deassert `run` in ON cycle 2 → `en` stays high through cycle 4, then `busy`=0 with `en`=0. Deassert during BLANK instead → IDLE next edge and `en` never rises.
4. Mask set to 0 mid-dwell of digit 2 → dwell completes, then IDLE. Restore mask=4'b0100 → restart at `sel`=2.
5. BLANK=0, DWELL=1, mask=4'b0001 → `en` constantly 1, `sel`=0, `frame_done` high every cycle after the first.
6. Drive `reset_n` low asynchronously mid-ON → `en`, `sel`, `busy` go 0 without waiting for a clock edge. Release reset → IDLE until `run` is sampled.
